ram_arbiter: RTL and testbench

Two-port arbiter and sequencer placed in front of the single-port byte-writable block RAM. It shares that RAM between two requesters, typically port 0 for instruction fetch and port 1 for load/store. For each requester it converts byte addresses to word indices, drives the RAM chip-enable, write-enable, address and write-data inputs, and routes the 1-cycle-latency read data back to the port that issued the access. A response holding register absorbs requester backpressure, and out-of-range accesses are rejected without touching the RAM.

---
 rtl/ram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port byte-writable RAM.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin on contention, else port 1 wins.
module ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SRAM_DEPTH = 1024
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic                    i_P0_REQ,
  input  logic [ADDR_WIDTH-1:0]   i_P0_ADDR,
  input  logic [DATA_WIDTH-1:0]   i_P0_WDATA,
  input  logic [DATA_WIDTH/8-1:0] i_P0_WE,
  output logic                    o_P0_GNT,
  output logic                    o_P0_RVALID,
  output logic [DATA_WIDTH-1:0]   o_P0_RDATA,
  output logic                    o_P0_ERR,
  input  logic                    i_P0_RREADY,
  input  logic                    i_P1_REQ,
  input  logic [ADDR_WIDTH-1:0]   i_P1_ADDR,
  input  logic [DATA_WIDTH-1:0]   i_P1_WDATA,
  input  logic [DATA_WIDTH/8-1:0] i_P1_WE,
  output logic                    o_P1_GNT,
  output logic                    o_P1_RVALID,
  output logic [DATA_WIDTH-1:0]   o_P1_RDATA,
  output logic                    o_P1_ERR,
  input  logic                    i_P1_RREADY,
  output logic                    o_RAM_CE,
  output logic [ADDR_WIDTH-1:0]   o_RAM_ADDR,
  output logic [DATA_WIDTH-1:0]   o_RAM_WDATA,
  output logic [DATA_WIDTH/8-1:0] o_RAM_WE,
  input  logic [DATA_WIDTH-1:0]   i_RAM_RDATA
);

  localparam int N_COLS = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(SRAM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  err_q, err_d;
  logic                  rd_q, rd_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_err_q, hold_err_d;

  logic                  own_rready;
  logic                  can_issue;
  logic                  issue;
  logic                  sel;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [ADDR_WIDTH-1:0] widx;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic [N_COLS-1:0]     we_sel;
  logic [DATA_WIDTH-1:0] wait_data;

  assign own_rready = owner_q ? i_P1_RREADY : i_P0_RREADY;

  always_comb begin
    can_issue = 1'b0;
    case (state_q)
      S_IDLE:  can_issue = i_RST_N;
      S_WAIT:  can_issue = i_RST_N & own_rready;
      default: can_issue = 1'b0;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On contention favour whichever port lost the previous grant.
  assign sel    = (i_P0_REQ & i_P1_REQ) ? ~last_q : i_P1_REQ;
  assign last_d = issue ? sel : last_q;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) last_q <= 1'b0;
    else          last_q <= last_d;
  end
`else
  assign sel = i_P1_REQ;
`endif

  assign issue     = can_issue & (i_P0_REQ | i_P1_REQ);
  assign addr_sel  = sel ? i_P1_ADDR  : i_P0_ADDR;
  assign wdata_sel = sel ? i_P1_WDATA : i_P0_WDATA;
  assign we_sel    = sel ? i_P1_WE    : i_P0_WE;
  assign widx      = addr_sel >> 2;
  assign in_range  = widx < DEPTH_W;
  assign wait_data = (rd_q & ~err_q) ? i_RAM_RDATA : '0;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    err_d       = err_q;
    rd_d        = rd_q;
    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;
    case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        if (own_rready) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_HOLD;
          hold_data_d = wait_data;
          hold_err_d  = err_q;
        end
      end
      S_HOLD: if (own_rready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      state_d = S_WAIT;
      owner_d = sel;
      err_d   = ~in_range;
      rd_d    = ~|we_sel;
    end
  end

  always_comb begin
    logic                  vld;
    logic [DATA_WIDTH-1:0] dat;
    logic                  er;
    vld = (state_q == S_WAIT) | (state_q == S_HOLD);
    dat = (state_q == S_WAIT) ? wait_data : hold_data_q;
    er  = (state_q == S_WAIT) ? err_q : hold_err_q;

    o_P0_GNT    = issue & ~sel;
    o_P1_GNT    = issue & sel;
    o_P0_RVALID = vld & ~owner_q;
    o_P1_RVALID = vld & owner_q;
    o_P0_RDATA  = o_P0_RVALID ? dat : '0;
    o_P1_RDATA  = o_P1_RVALID ? dat : '0;
    o_P0_ERR    = o_P0_RVALID & er;
    o_P1_ERR    = o_P1_RVALID & er;

    o_RAM_CE    = issue & in_range;
    o_RAM_ADDR  = o_RAM_CE ? widx      : '0;
    o_RAM_WDATA = o_RAM_CE ? wdata_sel : '0;
    o_RAM_WE    = o_RAM_CE ? we_sel    : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 1-cycle RAM.
// Expected responses are queued at grant time and checked on RVALID&RREADY.
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req, gnt, rvalid, rready, err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  we [2];
  logic        ram_ce;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_we;

  typedef struct {
    int          port;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [1024];
  int          checks = 0;
  int          failures = 0;

  ram_arbiter dut (
    .i_CLK       (clk),
    .i_RST_N     (rst_n),
    .i_P0_REQ    (req[0]),
    .i_P0_ADDR   (addr[0]),
    .i_P0_WDATA  (wdata[0]),
    .i_P0_WE     (we[0]),
    .o_P0_GNT    (gnt[0]),
    .o_P0_RVALID (rvalid[0]),
    .o_P0_RDATA  (rdata[0]),
    .o_P0_ERR    (err[0]),
    .i_P0_RREADY (rready[0]),
    .i_P1_REQ    (req[1]),
    .i_P1_ADDR   (addr[1]),
    .i_P1_WDATA  (wdata[1]),
    .i_P1_WE     (we[1]),
    .o_P1_GNT    (gnt[1]),
    .o_P1_RVALID (rvalid[1]),
    .o_P1_RDATA  (rdata[1]),
    .o_P1_ERR    (err[1]),
    .i_P1_RREADY (rready[1]),
    .o_RAM_CE    (ram_ce),
    .o_RAM_ADDR  (ram_addr),
    .o_RAM_WDATA (ram_wdata),
    .o_RAM_WE    (ram_we),
    .i_RAM_RDATA (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)    return 32'hDEAD_BEEF;
    if (i == 8)    return 32'h1122_3344;
    if (i == 1023) return 32'hCAFE_F00D;
    return 32'h5A00_0000 ^ (i * 32'h0001_0101);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural RAM; returns junk when not enabled so stale data is visible.
  initial begin
    logic [31:0] mem [1024];
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_ce) begin
        ram_rdata <= mem[ram_addr[9:0]];
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: pop responses, then push expectations for new grants.
  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (rvalid[p] && rready[p]) begin
            if (sb.size() == 0) begin
              chk("rsp_spurious", 64'(p + 1), 64'd0);
            end else begin
              exp_t e;
              e = sb.pop_front();
              chk("rsp_port", 64'(p), 64'(e.port));
              chk("rsp_data", 64'(rdata[p]), 64'(e.d));
              chk("rsp_err", 64'(err[p]), 64'(e.e));
            end
          end
        end
        if (gnt != 2'b00) chk("gnt_onehot", 64'(gnt == 2'b11), 64'd0);
        for (int p = 0; p < 2; p++) begin
          if (gnt[p]) begin
            exp_t        e;
            logic [31:0] idx;
            logic        ok;
            idx = addr[p] >> 2;
            ok  = idx < 32'd1024;
            chk("ram_ce", 64'(ram_ce), 64'(ok));
            if (ok) begin
              chk("ram_addr", 64'(ram_addr), 64'(idx));
              chk("ram_we", 64'(ram_we), 64'(we[p]));
              if (we[p] != 4'b0) chk("ram_wdata", 64'(ram_wdata), 64'(wdata[p]));
            end
            e.port = p;
            e.e    = ~ok;
            e.d    = (ok && we[p] == 4'b0) ? ref_mem[idx[9:0]] : 32'd0;
            if (ok)
              for (int b = 0; b < 4; b++)
                if (we[p][b]) ref_mem[idx[9:0]][8*b +: 8] = wdata[p][8*b +: 8];
            sb.push_back(e);
          end
        end
      end
    end
  end

  task automatic issue(input int p, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] w);
    bit got;
    got      = 1'b0;
    req[p]   = 1'b1;
    addr[p]  = a;
    wdata[p] = d;
    we[p]    = w;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = gnt[p];
    end
    if (!got) chk("gnt_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req[p] = 1'b0;
    we[p]  = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] held;
    rst_n  = 1'b0;
    req    = '0;
    rready = 2'b11;
    for (int p = 0; p < 2; p++) begin
      addr[p]  = '0;
      wdata[p] = '0;
      we[p]    = '0;
    end

    // Outputs stay quiet in reset even with a request pending
    #3;
    req[0] = 1'b1;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_ce", 64'(ram_ce), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_ramaddr", 64'(ram_addr), 64'd0);
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic read, then sub-word write followed by read-back
    issue(0, 32'h10, 32'h0, 4'b0000);
    drain();
    issue(1, 32'h20, 32'h0000_00AB, 4'b0001);
    issue(0, 32'h20, 32'h0, 4'b0000);
    drain();

    // Contention for six cycles, arbitration from a fresh reset
    rst_pulse();
    addr[0] = 32'h10;
    addr[1] = 32'h20;
    req     = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b10;
`endif
      chk("arb_gnt", 64'(gnt), 64'(exp_g));
      chk("arb_ce", 64'(ram_ce), 64'd1);
    end
    @(posedge clk);
    #1;
    req = 2'b00;
    drain();

    // Backpressure: WAIT then HOLD, port 1 must not be granted
    rready[0] = 1'b0;
    issue(0, 32'h10, 32'h0, 4'b0000);
    req[1]  = 1'b1;
    addr[1] = 32'h14;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_rvalid", 64'(rvalid[0]), 64'd1);
      chk("hold_rdata", 64'(rdata[0]), 64'h0000_0000_DEAD_BEEF);
      chk("hold_gnt1", 64'(gnt[1]), 64'd0);
    end
    @(posedge clk);
    #1;
    rready[0] = 1'b1;
    @(negedge clk);
    chk("hold_rel_gnt1", 64'(gnt[1]), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_rvalid", 64'(rvalid[0]), 64'd0);
    chk("idle_gnt1", 64'(gnt[1]), 64'd1);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    drain();

    // Range boundaries, including upper address bits
    issue(0, 32'h1000, 32'h0, 4'b0000);
    issue(0, 32'hFFC, 32'h0, 4'b0000);
    issue(1, 32'h8000_0010, 32'h0, 4'b0000);
    issue(1, 32'h1000, 32'h1234_5678, 4'b1111);
    drain();

    // Reset in the middle of an access
    issue(0, 32'h10, 32'h0, 4'b0000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postrst_rvalid", 64'(rvalid), 64'd0);
    end
    @(posedge clk);
    #1;
    held = 32'h1000_0000;
    issue(1, held, 32'h0, 4'b0000);
    issue(0, 32'h10, 32'h0, 4'b0000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
